// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: channel count, slot-index width,
// and the receive-side framing state encoding.
package tdm_pkg;

  localparam int CH   = 8;
  localparam int SELW = 3;

  // Slot index type, also used by the transmit-side mux sequencer.
  typedef logic [SELW-1:0] slot_t;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter for the TDM receiver. It drives the slot index
// (sel) that the next strobed bit will occupy.
// Control priority: reset, clear, load-to-1, advance.
module tdm_slot_ctr #(
  parameter int SELW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load1_i,
  input  logic            adv_i,
  output logic [SELW-1:0] sel_o
);

  logic [SELW-1:0] sel_q, sel_d;

  // Next slot index; advancing past the last slot wraps to 0.
  always_comb begin
    sel_d = sel_q;
    if (clr_i)        sel_d = '0;
    else if (load1_i) sel_d = SELW'(1);
    else if (adv_i)   sel_d = sel_q + 1'b1;
  end

  // Slot index register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) sel_q <= '0;
    else       sel_q <= sel_d;
  end

  assign sel_o = sel_q;

endmodule

// File: rtl/tdm_demux8.sv
// Receive-side TDM demultiplexer. It aligns to the frame-sync marker and
// collects one bit per slot into a shadow register. On the slot-7 bit it
// publishes the complete frame on y together with a one-cycle valid pulse.
module tdm_demux8 #(
  parameter int CH   = 8,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic            en,
  input  logic            sync,
  output logic [CH-1:0]   y,
  output logic            valid,
  output logic [SELW-1:0] sel,
  output logic            locked,
  output logic            err
);
  import tdm_pkg::*;

  localparam logic [SELW-1:0] LAST = SELW'(CH - 1);

  state_e          state_q;
  // Slot CH-1 feeds y directly, so only slots 0..CH-2 need shadow storage.
  logic [CH-2:0]   shadow_q;
  logic [CH-1:0]   y_q;
  logic            valid_q;
  logic            locked_q;
  logic            err_q;

  logic            ctr_clr;
  logic            ctr_load1;
  logic            ctr_adv;

  // Slot counter controls. Any qualified sync restarts at slot 1. In RUN,
  // a missing sync or a completed frame clears the counter to 0.
  always_comb begin
    ctr_load1 = en && sync;
    ctr_clr   = 1'b0;
    ctr_adv   = 1'b0;
    if (en && !sync && (state_q == RUN)) begin
      if ((sel == '0) || (sel == LAST)) ctr_clr = 1'b1;
      else                              ctr_adv = 1'b1;
    end
  end

  tdm_slot_ctr #(
    .SELW(SELW)
  ) u_slot_ctr (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (ctr_clr),
    .load1_i(ctr_load1),
    .adv_i  (ctr_adv),
    .sel_o  (sel)
  );

  // Framing FSM, shadow capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (en) begin
        unique case (state_q)
          HUNT: begin
            if (sync) begin
              shadow_q[0] <= din;
              locked_q    <= 1'b1;
              state_q     <= RUN;
            end
          end
          RUN: begin
            // A sync always restarts the frame. If it arrives anywhere but
            // slot 0, the partial frame is dropped and flagged.
            if (sync) begin
              shadow_q[0] <= din;
              if (sel != '0) err_q <= 1'b1;
            end else if (sel == '0) begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= HUNT;
            end else if (sel == LAST) begin
              y_q     <= {din, shadow_q};
              valid_q <= 1'b1;
            end else begin
              shadow_q[sel] <= din;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign y      = y_q;
  assign valid  = valid_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized scoreboard bench for tdm_demux8 with a slot-level reference model.
module tb_tdm_demux8;
  localparam int CH   = 8;
  localparam int SELW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic en  = 1'b0;
  logic sync = 1'b0;
  logic [CH-1:0]   y;
  logic            valid;
  logic [SELW-1:0] sel;
  logic            locked;
  logic            err;

  always #5 clk = ~clk;

  tdm_demux8 #(.CH(CH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
    .y(y), .valid(valid), .sel(sel), .locked(locked), .err(err)
  );

  typedef struct packed {
    logic [CH-1:0]   y;
    logic            valid;
    logic [SELW-1:0] sel;
    logic            locked;
    logic            err;
  } exp_t;

  exp_t          exp_q[$];
  logic [CH-1:0] frame_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: aligned flag, next slot number, received bits.
  bit            m_locked = 1'b0;
  int            m_slot   = 0;
  bit            m_bits[CH];
  logic [CH-1:0] m_y      = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs and push the expected post-edge outputs.
  task automatic step(input bit r, input bit e, input bit s, input bit d);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sync = s; din = d;
    x.valid = 1'b0;
    x.err   = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_slot   = 0;
      m_y      = '0;
      for (int i = 0; i < CH; i++) m_bits[i] = 1'b0;
    end else if (e) begin
      if (!m_locked) begin
        if (s) begin
          m_bits[0] = d; m_slot = 1; m_locked = 1'b1;
        end
      end else if (s) begin
        if (m_slot != 0) x.err = 1'b1;
        m_bits[0] = d;
        m_slot = 1;
      end else if (m_slot == 0) begin
        x.err = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_bits[m_slot] = d;
        if (m_slot == CH - 1) begin
          for (int i = 0; i < CH; i++) m_y[i] = m_bits[i];
          frame_q.push_back(m_y);
          x.valid = 1'b1;
          m_slot = 0;
        end else begin
          m_slot = m_slot + 1;
        end
      end
    end
    x.y      = m_y;
    x.sel    = m_locked ? SELW'(m_slot) : '0;
    x.locked = m_locked;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [CH-1:0] b, input bit bubbles);
    for (int k = 0; k < CH; k++) begin
      if (bubbles) repeat ($urandom % 3) step(1'b0, 1'b0, 1'($urandom % 2), 1'($urandom % 2));
      step(1'b0, 1'b1, (k == 0), b[k]);
    end
  endtask

  // Monitor: per-cycle output comparison plus frame scoreboard on valid.
  exp_t          mx;
  logic [CH-1:0] mf;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      check("valid",  32'(valid),  32'(mx.valid));
      check("err",    32'(err),    32'(mx.err));
      check("sel",    32'(sel),    32'(mx.sel));
      check("locked", 32'(locked), 32'(mx.locked));
      check("y_hold", 32'(y),      32'(mx.y));
    end
    if (valid === 1'b1) begin
      if (frame_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_unexpected t=%0t actual=valid required=no_valid", $time);
      end else begin
        mf = frame_q.pop_front();
        check("frame_y", 32'(y), 32'(mf));
      end
    end
  end

  initial begin
    logic [CH-1:0] b;
    bit s;
    // Reset held two cycles with en/sync active.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Aligned frame: i0..i7 = 0,1,0,0,0,1,0,1.
    b = 8'b1010_0010;
    send_frame(b, 1'b0);
    @(posedge clk); #2;
    check("aligned_y", 32'(y), 32'h0000_00A2);
    check("aligned_valid", 32'(valid), 32'd1);

    // Back-to-back frames with bubbles.
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);

    // Early sync at slot 4, then the rest of a frame.
    b = 8'h5B;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, (k == 0), b[k]);
    step(1'b0, 1'b1, 1'b1, b[0]);
    for (int k = 1; k < CH; k++) step(1'b0, 1'b1, 1'b0, b[k]);

    // Missing sync at slot 0, ignored bits in HUNT, then relock.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'($urandom % 2));
    send_frame(8'hC3, 1'b0);

    // Reset mid-frame at slot 5, then a clean frame.
    b = 8'hFF;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, (k == 0), b[k]);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h96, 1'b1);

    // Randomized traffic, mostly well-formed with occasional faults.
    repeat (400) begin
      if (m_slot == 0) s = ($urandom % 8) != 0;
      else             s = ($urandom % 20) == 0;
      step(1'b0, 1'(($urandom % 4) != 0), s, 1'($urandom % 2));
    end
    send_frame(8'h81, 1'b0);

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("frames_drained", 32'(frame_q.size()), 32'd0);
    check("exp_drained",    32'(exp_q.size()),   32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
